irq_arbiter: RTL and testbench

- Machine-level interrupt arbiter between the interrupt sources and core_controller_fsm.
- Registers the pending sources (MSI, MTI, MEI) into an mip image and applies the mie/mstatus.MIE masks.
- Picks one winner by fixed priority and presents it to the controller with a req/ack handshake and an mcause value.
- Blocks further requests until the handler's MRET retires.

---
 rtl/irq_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_irq_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// Machine-level interrupt arbiter.
// Samples MSI/MTI/MEI into an mip image and masks them with mie and mstatus.MIE.
// Picks one winner by fixed priority (MEI > MSI > MTI) and offers it to the
// controller through a req/ack handshake. Holds off new requests until the
// handler's MRET retires.
module irq_arbiter #(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mie,
    input  logic            sw_irq,
    input  logic            timer_irq,
    input  logic            ext_irq,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    input  logic            irq_ack,
    input  logic            irq_done,
    output logic [XLEN-1:0] mip_o,
    output logic            in_service,
    output logic            ack_timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam int            CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : {CW{1'b0}};
    localparam logic          TMO_EN   = (ACK_TIMEOUT != 0);

    localparam logic [3:0] CODE_MSI = 4'd3;
    localparam logic [3:0] CODE_MTI = 4'd7;
    localparam logic [3:0] CODE_MEI = 4'd11;

    // Fixed-priority pick; elig is {MEI, MTI, MSI}
    function automatic logic [3:0] pick_code(input logic [2:0] elig);
        logic [3:0] code;
        if (elig[2]) begin
            code = CODE_MEI;
        end else if (elig[0]) begin
            code = CODE_MSI;
        end else begin
            code = CODE_MTI;
        end
        return code;
    endfunction

    // Is the source behind a latched cause code still eligible?
    function automatic logic code_eligible(input logic [3:0] code, input logic [2:0] elig);
        logic hit;
        case (code)
            CODE_MEI: hit = elig[2];
            CODE_MTI: hit = elig[1];
            CODE_MSI: hit = elig[0];
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t          state_q;
    logic [2:0]      pend_q;          // {MEI, MTI, MSI}
    logic            irq_req_q;
    logic            in_service_q;
    logic            err_q;
    logic [XLEN-1:0] cause_q;
    logic [CW-1:0]   cnt_q;

    logic [2:0]      elig_s;
    logic            latched_elig_s;
    logic            tmo_hit_s;
    logic            mti_clr_s;
    logic [XLEN-1:0] cause_new_s;
    logic            unused_mie_s;

    // Only bits 3/7/11 of mie matter; fold the rest away
    assign unused_mie_s = ^mie;

    // Eligibility, timeout detection and the MTI clear-on-ack condition
    always_comb begin
        elig_s         = pend_q & {mie[11], mie[7], mie[3]} & {3{mstatus_mie}};
        latched_elig_s = code_eligible(cause_q[3:0], elig_s);
        cause_new_s    = {1'b1, {(XLEN-5){1'b0}}, pick_code(elig_s)};
        if (TMO_EN && (cnt_q == TMO_LAST)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
        if (enable && (state_q == ST_REQ) && irq_ack && (cause_q[3:0] == CODE_MTI)) begin
            mti_clr_s = 1'b1;
        end else begin
            mti_clr_s = 1'b0;
        end
    end

    // Pending image: MSI/MEI are level samples, MTI is sticky until its ack (set wins)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 3'b000;
        end else begin
            pend_q[0] <= sw_irq;
            pend_q[1] <= timer_irq | (pend_q[1] & ~mti_clr_s);
            pend_q[2] <= ext_irq;
        end
    end

    // Handshake FSM with registered req/in_service/error outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            err_q        <= 1'b0;
            cause_q      <= {XLEN{1'b0}};
            cnt_q        <= {CW{1'b0}};
        end else begin
            err_q <= 1'b0;
            if (!enable) begin
                state_q      <= ST_IDLE;
                irq_req_q    <= 1'b0;
                in_service_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (|elig_s) begin
                            state_q   <= ST_REQ;
                            irq_req_q <= 1'b1;
                            cause_q   <= cause_new_s;
                            cnt_q     <= {CW{1'b0}};
                        end
                    end
                    ST_REQ: begin
                        if (irq_ack) begin
                            state_q      <= ST_SERVICE;
                            irq_req_q    <= 1'b0;
                            in_service_q <= 1'b1;
                        end else if (!latched_elig_s) begin
                            state_q   <= ST_IDLE;
                            irq_req_q <= 1'b0;
                        end else if (tmo_hit_s) begin
                            state_q   <= ST_IDLE;
                            irq_req_q <= 1'b0;
                            err_q     <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_SERVICE: begin
                        if (irq_done) begin
                            state_q      <= ST_IDLE;
                            in_service_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        irq_req_q    <= 1'b0;
                        in_service_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output mapping; every bit comes straight from a flop
    always_comb begin
        mip_o           = {XLEN{1'b0}};
        mip_o[3]        = pend_q[0];
        mip_o[7]        = pend_q[1];
        mip_o[11]       = pend_q[2];
        irq_req         = irq_req_q;
        irq_cause       = cause_q;
        in_service      = in_service_q;
        ack_timeout_err = err_q;
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: a behavioural model compared every cycle plus
// hand-computed literal checks along directed scenarios.
module tb_irq_arbiter;

    localparam int XLEN = 32;
    localparam int TMO  = 4;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SVC  = 2;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            mstatus_mie;
    logic [XLEN-1:0] mie;
    logic            sw_irq;
    logic            timer_irq;
    logic            ext_irq;
    logic            irq_req;
    logic [XLEN-1:0] irq_cause;
    logic            irq_ack;
    logic            irq_done;
    logic [XLEN-1:0] mip_o;
    logic            in_service;
    logic            ack_timeout_err;

    int total = 0;
    int bad   = 0;

    irq_arbiter #(.XLEN(XLEN), .ACK_TIMEOUT(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .mstatus_mie     (mstatus_mie),
        .mie             (mie),
        .sw_irq          (sw_irq),
        .timer_irq       (timer_irq),
        .ext_irq         (ext_irq),
        .irq_req         (irq_req),
        .irq_cause       (irq_cause),
        .irq_ack         (irq_ack),
        .irq_done        (irq_done),
        .mip_o           (mip_o),
        .in_service      (in_service),
        .ack_timeout_err (ack_timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ph, n_ph, m_wait, n_wait, win;
    logic [31:0] m_mip, n_mip, m_cause, n_cause, elig;
    logic        m_err, n_err, clr7;

    always_comb begin
        n_ph    = m_ph;
        n_wait  = m_wait;
        n_cause = m_cause;
        n_err   = 1'b0;
        clr7    = 1'b0;
        elig    = m_mip & mie & (mstatus_mie ? 32'hFFFF_FFFF : 32'h0);
        if (elig[11])     win = 11;
        else if (elig[3]) win = 3;
        else if (elig[7]) win = 7;
        else              win = -1;
        if (!enable) begin
            n_ph = PH_IDLE;
        end else if (m_ph == PH_IDLE) begin
            if (win >= 0) begin
                n_ph    = PH_REQ;
                n_cause = 32'h8000_0000 | 32'(win);
                n_wait  = 0;
            end
        end else if (m_ph == PH_REQ) begin
            if (irq_ack) begin
                n_ph = PH_SVC;
                clr7 = (m_cause == 32'h8000_0007);
            end else if (!elig[m_cause[4:0]]) begin
                n_ph = PH_IDLE;
            end else if (TMO != 0 && m_wait == TMO - 1) begin
                n_ph  = PH_IDLE;
                n_err = 1'b1;
            end else begin
                n_wait = m_wait + 1;
            end
        end else begin
            if (irq_done) n_ph = PH_IDLE;
        end
        n_mip = (sw_irq ? 32'h8 : 32'h0) | (ext_irq ? 32'h800 : 32'h0)
              | ((timer_irq || (m_mip[7] && !clr7)) ? 32'h80 : 32'h0);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph    <= PH_IDLE;
            m_wait  <= 0;
            m_mip   <= 32'h0;
            m_cause <= 32'h0;
            m_err   <= 1'b0;
        end else begin
            m_ph    <= n_ph;
            m_wait  <= n_wait;
            m_mip   <= n_mip;
            m_cause <= n_cause;
            m_err   <= n_err;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_req",   {31'b0, irq_req},         {31'b0, (m_ph == PH_REQ)});
        chk("m_svc",   {31'b0, in_service},      {31'b0, (m_ph == PH_SVC)});
        chk("m_err",   {31'b0, ack_timeout_err}, {31'b0, m_err});
        chk("m_mip",   mip_o,                    m_mip);
        chk("m_cause", irq_cause,                m_cause);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; enable = 1'b0; mstatus_mie = 1'b0; mie = 32'h0;
        sw_irq = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0;
        irq_ack = 1'b0; irq_done = 1'b0;
        #1 reset = 1'b1;
        tick(2);
        chk("rst_req",   {31'b0, irq_req},    32'h0);
        chk("rst_mip",   mip_o,               32'h0);
        chk("rst_cause", irq_cause,           32'h0);
        chk("rst_svc",   {31'b0, in_service}, 32'h0);
        reset = 1'b0; enable = 1'b1; mstatus_mie = 1'b1; mie = 32'h80;
        tick(1);

        // T1: single timer pulse, ack, done
        timer_irq = 1'b1; tick(1); timer_irq = 1'b0;
        chk("t1_mip",   mip_o,             32'h80);
        chk("t1_req0",  {31'b0, irq_req},  32'h0);
        tick(1);
        chk("t1_req",   {31'b0, irq_req},  32'h1);
        chk("t1_cause", irq_cause,         32'h8000_0007);
        tick(2); irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        chk("t1_mipclr", mip_o,               32'h0);
        chk("t1_svc",    {31'b0, in_service}, 32'h1);
        irq_done = 1'b1; tick(1); irq_done = 1'b0; tick(2);
        chk("t1_norereq", {31'b0, irq_req},    32'h0);
        chk("t1_idle",    {31'b0, in_service}, 32'h0);

        // T2: priority 11 > 3 > 7
        mie = 32'h888; ext_irq = 1'b1; sw_irq = 1'b1; timer_irq = 1'b1;
        tick(1); timer_irq = 1'b0; tick(1);
        chk("t2_causeB", irq_cause, 32'h8000_000B);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0; ext_irq = 1'b0;
        irq_done = 1'b1; tick(1); irq_done = 1'b0; tick(1);
        chk("t2_cause3", irq_cause, 32'h8000_0003);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0; sw_irq = 1'b0;
        irq_done = 1'b1; tick(1); irq_done = 1'b0; tick(1);
        chk("t2_cause7", irq_cause, 32'h8000_0007);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        irq_done = 1'b1; tick(1); irq_done = 1'b0; tick(1);
        chk("t2_quiet", {31'b0, irq_req}, 32'h0);

        // T3: withdraw when the source drops before ack
        mie = 32'h8; sw_irq = 1'b1; tick(2);
        chk("t3_req",   {31'b0, irq_req}, 32'h1);
        chk("t3_cause", irq_cause,        32'h8000_0003);
        sw_irq = 1'b0; tick(2);
        chk("t3_wd_req", {31'b0, irq_req},         32'h0);
        chk("t3_wd_err", {31'b0, ack_timeout_err}, 32'h0);

        // T4: timeout after 4 request cycles, sticky timer re-arbitrates
        mie = 32'h80; timer_irq = 1'b1; tick(1); timer_irq = 1'b0; tick(1);
        chk("t4_req_c1", {31'b0, irq_req}, 32'h1);
        tick(3);
        chk("t4_req_c4", {31'b0, irq_req},         32'h1);
        chk("t4_noerr",  {31'b0, ack_timeout_err}, 32'h0);
        tick(1);
        chk("t4_req_drop", {31'b0, irq_req},         32'h0);
        chk("t4_err",      {31'b0, ack_timeout_err}, 32'h1);
        chk("t4_mipkeep",  mip_o,                    32'h80);
        tick(1);
        chk("t4_rereq",  {31'b0, irq_req},         32'h1);
        chk("t4_errend", {31'b0, ack_timeout_err}, 32'h0);
        chk("t4_cause",  irq_cause,                32'h8000_0007);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        irq_done = 1'b1; tick(1); irq_done = 1'b0; tick(1);

        // T5: no nesting during service; ack beats withdraw
        mie = 32'h808; sw_irq = 1'b1; tick(2);
        chk("t5_cause3", irq_cause, 32'h8000_0003);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0; sw_irq = 1'b0; ext_irq = 1'b1;
        tick(3);
        chk("t5_nonest", {31'b0, irq_req},    32'h0);
        chk("t5_insvc",  {31'b0, in_service}, 32'h1);
        chk("t5_accum",  mip_o,               32'h800);
        irq_done = 1'b1; tick(1); irq_done = 1'b0; tick(1);
        chk("t5_causeB", irq_cause, 32'h8000_000B);
        ext_irq = 1'b0; tick(1); irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        chk("t5_ackwins", {31'b0, in_service}, 32'h1);
        irq_done = 1'b1; tick(1); irq_done = 1'b0; tick(1);
        chk("t5_quiet", {31'b0, irq_req}, 32'h0);

        // T6: async reset mid-REQ, then enable drop during service
        mie = 32'h80; timer_irq = 1'b1; tick(1); timer_irq = 1'b0; tick(1);
        chk("t6_req", {31'b0, irq_req}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_req", {31'b0, irq_req},    32'h0);
        chk("t6_rst_mip", mip_o,               32'h0);
        chk("t6_rst_svc", {31'b0, in_service}, 32'h0);
        tick(1); reset = 1'b0; tick(1);
        timer_irq = 1'b1; tick(1); timer_irq = 1'b0; tick(1);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        chk("t6_svc", {31'b0, in_service}, 32'h1);
        timer_irq = 1'b1; tick(1); timer_irq = 1'b0;
        chk("t6_pend", mip_o, 32'h80);
        enable = 1'b0; tick(1);
        chk("t6_dis_svc", {31'b0, in_service}, 32'h0);
        chk("t6_dis_req", {31'b0, irq_req},    32'h0);
        chk("t6_dis_mip", mip_o,               32'h80);
        tick(1);
        chk("t6_dis_hold", {31'b0, irq_req}, 32'h0);
        enable = 1'b1; tick(1);
        chk("t6_en_req",   {31'b0, irq_req}, 32'h1);
        chk("t6_en_cause", irq_cause,        32'h8000_0007);
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
        irq_done = 1'b1; tick(1); irq_done = 1'b0; tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
